// File: rtl/tlul_pkg.sv
// TL-UL bus types shared by the register responder and its bench.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_req_err.sv
// Combinational legality check of a TL-UL A-channel request.
module tlul_req_err
  import tlul_pkg::*;
(
  input  tl_h2d_t tl_i,
  output logic    err_o
);

  logic [3:0] lanes;
  logic       misaligned;
  logic       op_err;
  logic       size_err;
  logic       mask_err;
  logic       full_err;

  // Fields that play no part in legality.
  logic unused_tl;
  assign unused_tl = ^{tl_i.a_valid, tl_i.a_param, tl_i.a_source, tl_i.a_data,
                       tl_i.d_ready, tl_i.a_address[TL_AW-1:2]};

  // Byte lanes covered by size and low address bits, plus alignment.
  always_comb begin
    lanes      = 4'b0000;
    misaligned = 1'b0;
    case (tl_i.a_size)
      2'd0: lanes = 4'b0001 << tl_i.a_address[1:0];
      2'd1: begin
        lanes      = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
        misaligned = tl_i.a_address[0];
      end
      2'd2: begin
        lanes      = 4'b1111;
        misaligned = |tl_i.a_address[1:0];
      end
      default: lanes = 4'b1111;  // size 3 is rejected by size_err
    endcase
  end

  // Combine the individual error conditions.
  always_comb begin
    op_err   = !((tl_i.a_opcode == PutFullData) ||
                 (tl_i.a_opcode == PutPartialData) ||
                 (tl_i.a_opcode == Get));
    size_err = (tl_i.a_size == 2'd3);
    mask_err = |(tl_i.a_mask & ~lanes);
    full_err = (tl_i.a_opcode == PutFullData) && ((tl_i.a_mask & lanes) != lanes);
    err_o    = op_err | size_err | misaligned | mask_err | full_err;
  end

endmodule

// File: rtl/tlul_reg_responder.sv
// TL-UL device adapter: one outstanding request turned into a level
// register strobe held until reg_ready_i, then a single D response.
//
// Handshakes: a transfer happens on a channel in a cycle where valid and
// ready are both high; valid and its payload hold steady until then and
// valid never waits for ready.
module tlul_reg_responder
  import tlul_pkg::*;
#(
  parameter int RegAw = 8,
  parameter int RegDw = 32   // only 32 is supported
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  tl_h2d_t            tl_i,
  output tl_d2h_t            tl_o,
  output logic               reg_we_o,
  output logic               reg_re_o,
  output logic [RegAw-1:0]   reg_addr_o,
  output logic [RegDw-1:0]   reg_wdata_o,
  output logic [RegDw/8-1:0] reg_be_o,
  input  logic [RegDw-1:0]   reg_rdata_i,
  input  logic               reg_error_i,
  input  logic               reg_ready_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e state;
  state_e state_next;

  logic               req_err;
  logic               accept;
  tl_a_op_e           op_q;
  logic [TL_SZW-1:0]  size_q;
  logic [TL_AIW-1:0]  source_q;
  logic [RegAw-1:2]   addr_q;
  logic [RegDw/8-1:0] mask_q;
  logic [RegDw-1:0]   wdata_q;
  logic               req_err_q;
  logic [RegDw-1:0]   rdata_q;
  logic               rerr_q;
  logic               is_get;
  logic               is_put;

  // Upper/low address bits and a_param are not used by a word register port.
  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[TL_AW-1:RegAw],
                       tl_i.a_address[1:0]};

  tlul_req_err u_req_err (
    .tl_i  (tl_i),
    .err_o (req_err)
  );

  assign accept = (state == IDLE) && tl_i.a_valid;
  assign is_get = (op_q == Get);
  assign is_put = (op_q == PutFullData) || (op_q == PutPartialData);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; reg_ready_i only matters in ACCESS.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tl_i.a_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  if (reg_ready_i)  state_next = RESP;
      RESP:    if (tl_i.d_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture on accept, register result capture on completion.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q      <= PutFullData;
      size_q    <= '0;
      source_q  <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      wdata_q   <= '0;
      req_err_q <= 1'b0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
    end else if (accept) begin
      op_q      <= tl_i.a_opcode;
      size_q    <= tl_i.a_size;
      source_q  <= tl_i.a_source;
      addr_q    <= tl_i.a_address[RegAw-1:2];
      mask_q    <= tl_i.a_mask;
      wdata_q   <= tl_i.a_data;
      req_err_q <= req_err;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
    end else if ((state == ACCESS) && reg_ready_i) begin
      rdata_q <= reg_rdata_i;
      rerr_q  <= reg_error_i;
    end
  end

  // Outputs decoded from state and the captured request.
  always_comb begin
    reg_we_o    = (state == ACCESS) && is_put;
    reg_re_o    = (state == ACCESS) && is_get;
    reg_addr_o  = {addr_q, 2'b00};
    reg_wdata_o = wdata_q;
    reg_be_o    = mask_q;

    tl_o          = '0;
    tl_o.a_ready  = (state == IDLE);
    tl_o.d_valid  = (state == RESP);
    tl_o.d_opcode = is_get ? AccessAckData : AccessAck;
    tl_o.d_param  = 3'd0;
    tl_o.d_size   = size_q;
    tl_o.d_source = source_q;
    tl_o.d_sink   = '0;
    tl_o.d_error  = req_err_q | rerr_q;
    if (!is_get) begin
      tl_o.d_data = '0;
    end else if (req_err_q | rerr_q) begin
      tl_o.d_data = '1;
    end else begin
      tl_o.d_data = rdata_q;
    end
  end

endmodule

// File: tb/tb_tlul_reg_responder.sv
// Directed bench for tlul_reg_responder.
module tb_tlul_reg_responder;
  import tlul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  tl_h2d_t     tl_i;
  tl_d2h_t     tl_o;
  logic        reg_we, reg_re;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic        reg_ready;

  int n_checks = 0;
  int n_fail   = 0;

  tlul_reg_responder #(.RegAw(8), .RegDw(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tl_i        (tl_i),
    .tl_o        (tl_o),
    .reg_we_o    (reg_we),
    .reg_re_o    (reg_re),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_be_o    (reg_be),
    .reg_rdata_i (reg_rdata),
    .reg_error_i (reg_error),
    .reg_ready_i (reg_ready)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input tl_a_op_e op, input logic [7:0] addr, input logic [1:0] size,
                         input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_param   = 3'd0;
    tl_i.a_size    = size;
    tl_i.a_source  = src;
    tl_i.a_address = {24'h0, addr};
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
  endtask

  // Full transaction: request, optional register access with 'delay'
  // wait cycles, response checked and accepted.
  task automatic run_txn(input string tag, input tl_a_op_e op, input logic [7:0] addr,
                         input logic [1:0] size, input logic [3:0] mask, input logic [31:0] wdata,
                         input logic [7:0] src, input int delay, input logic [31:0] rdata,
                         input logic rerr, input logic exp_strobe, input logic exp_we,
                         input logic [7:0] exp_addr, input logic [3:0] exp_be,
                         input tl_d_op_e exp_op, input logic [31:0] exp_data, input logic exp_err);
    check({tag, ".a_ready_idle"}, 32'(tl_o.a_ready), 32'd1);
    drive_a(op, addr, size, mask, wdata, src);
    tl_i.d_ready = 1'b0;
    step();
    tl_i.a_valid = 1'b0;
    if (exp_strobe) begin
      check({tag, ".we"}, 32'(reg_we), 32'(exp_we));
      check({tag, ".re"}, 32'(reg_re), 32'(!exp_we));
      check({tag, ".addr"}, 32'(reg_addr), 32'(exp_addr));
      if (exp_we) begin
        check({tag, ".be"}, 32'(reg_be), 32'(exp_be));
        check({tag, ".wdata"}, reg_wdata, wdata);
      end
      for (int i = 0; i < delay; i++) begin
        step();
        check({tag, ".strobe_held"}, 32'(reg_we | reg_re), 32'd1);
        check({tag, ".no_dvalid_wait"}, 32'(tl_o.d_valid), 32'd0);
      end
      reg_ready = 1'b1;
      reg_rdata = rdata;
      reg_error = rerr;
      step();
      reg_ready = 1'b0;
      reg_rdata = 32'h0;
      reg_error = 1'b0;
    end
    check({tag, ".strobe_off"}, 32'({reg_we, reg_re}), 32'd0);
    check({tag, ".d_valid"}, 32'(tl_o.d_valid), 32'd1);
    check({tag, ".a_ready_busy"}, 32'(tl_o.a_ready), 32'd0);
    check({tag, ".d_opcode"}, 32'(tl_o.d_opcode), 32'(exp_op));
    check({tag, ".d_data"}, tl_o.d_data, exp_data);
    check({tag, ".d_error"}, 32'(tl_o.d_error), 32'(exp_err));
    check({tag, ".d_source"}, 32'(tl_o.d_source), 32'(src));
    check({tag, ".d_size"}, 32'(tl_o.d_size), 32'(size));
    tl_i.d_ready = 1'b1;
    step();
    tl_i.d_ready = 1'b0;
    check({tag, ".d_valid_done"}, 32'(tl_o.d_valid), 32'd0);
    check({tag, ".a_ready_after"}, 32'(tl_o.a_ready), 32'd1);
  endtask

  logic [31:0] held_data;

  initial begin
    tl_i      = '0;
    reg_rdata = 32'h0;
    reg_error = 1'b0;
    reg_ready = 1'b0;

    // Reset state.
    #12;
    check("rst.d_valid", 32'(tl_o.d_valid), 32'd0);
    check("rst.we", 32'(reg_we), 32'd0);
    check("rst.re", 32'(reg_re), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst.a_ready", 32'(tl_o.a_ready), 32'd1);

    // reg_ready outside ACCESS must be ignored.
    reg_ready = 1'b1;
    reg_error = 1'b1;
    step();
    reg_ready = 1'b0;
    reg_error = 1'b0;
    check("idle_ready.d_valid", 32'(tl_o.d_valid), 32'd0);
    check("idle_ready.a_ready", 32'(tl_o.a_ready), 32'd1);

    run_txn("get", Get, 8'h10, 2'd2, 4'hF, 32'h0, 8'h03, 2, 32'hDEADBEEF, 1'b0,
            1'b1, 1'b0, 8'h10, 4'hF, AccessAckData, 32'hDEADBEEF, 1'b0);
    run_txn("putpart", PutPartialData, 8'h06, 2'd1, 4'hC, 32'h12340000, 8'h05, 0, 32'h0, 1'b0,
            1'b1, 1'b1, 8'h04, 4'hC, AccessAck, 32'h0, 1'b0);
    run_txn("putfull", PutFullData, 8'h1C, 2'd2, 4'hF, 32'hCAFEF00D, 8'h07, 1, 32'h0, 1'b0,
            1'b1, 1'b1, 8'h1C, 4'hF, AccessAck, 32'h0, 1'b0);
    run_txn("misalign", Get, 8'h02, 2'd2, 4'hF, 32'h0, 8'h01, 0, 32'h0, 1'b0,
            1'b0, 1'b0, 8'h00, 4'h0, AccessAckData, 32'hFFFFFFFF, 1'b1);
    run_txn("full_mask", PutFullData, 8'h08, 2'd2, 4'h7, 32'h11111111, 8'h02, 0, 32'h0, 1'b0,
            1'b0, 1'b0, 8'h00, 4'h0, AccessAck, 32'h0, 1'b1);
    run_txn("bad_op", tl_a_op_e'(3'd3), 8'h00, 2'd2, 4'hF, 32'h0, 8'h04, 0, 32'h0, 1'b0,
            1'b0, 1'b0, 8'h00, 4'h0, AccessAck, 32'h0, 1'b1);
    run_txn("mask_lane", PutPartialData, 8'h01, 2'd0, 4'h4, 32'h0, 8'h06, 0, 32'h0, 1'b0,
            1'b0, 1'b0, 8'h00, 4'h0, AccessAck, 32'h0, 1'b1);
    run_txn("size3", Get, 8'h00, 2'd3, 4'hF, 32'h0, 8'h08, 0, 32'h0, 1'b0,
            1'b0, 1'b0, 8'h00, 4'h0, AccessAckData, 32'hFFFFFFFF, 1'b1);
    run_txn("rd_err", Get, 8'h0C, 2'd2, 4'hF, 32'h0, 8'h09, 1, 32'h55AA55AA, 1'b1,
            1'b1, 1'b0, 8'h0C, 4'hF, AccessAckData, 32'hFFFFFFFF, 1'b1);

    // Back-pressure: d_ready low 5 cycles, a_valid held high throughout.
    drive_a(Get, 8'h20, 2'd2, 4'hF, 32'h0, 8'h0A);
    tl_i.d_ready = 1'b0;
    step();
    check("bp.re", 32'(reg_re), 32'd1);
    reg_ready = 1'b1;
    reg_rdata = 32'hA5A5_0F0F;
    step();
    reg_ready = 1'b0;
    reg_rdata = 32'h0;
    drive_a(Get, 8'h24, 2'd2, 4'hF, 32'h0, 8'h0B);
    held_data = 32'hA5A5_0F0F;
    for (int i = 0; i < 5; i++) begin
      check("bp.a_ready", 32'(tl_o.a_ready), 32'd0);
      check("bp.d_valid", 32'(tl_o.d_valid), 32'd1);
      check("bp.d_data", tl_o.d_data, held_data);
      check("bp.d_source", 32'(tl_o.d_source), 32'h0A);
      check("bp.re_off", 32'(reg_re), 32'd0);
      step();
    end
    tl_i.d_ready = 1'b1;
    step();
    tl_i.d_ready = 1'b0;
    check("bp.a_ready_after", 32'(tl_o.a_ready), 32'd1);
    check("bp.d_valid_after", 32'(tl_o.d_valid), 32'd0);
    tl_i.a_valid = 1'b0;
    step();
    check("bp.no_accept", 32'(tl_o.a_ready), 32'd1);

    // Reset in the middle of ACCESS.
    drive_a(PutFullData, 8'h30, 2'd2, 4'hF, 32'h87654321, 8'h0C);
    step();
    tl_i.a_valid = 1'b0;
    check("rst_mid.we", 32'(reg_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid.we_drop", 32'(reg_we), 32'd0);
    check("rst_mid.re_drop", 32'(reg_re), 32'd0);
    check("rst_mid.d_valid", 32'(tl_o.d_valid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    reg_ready = 1'b1;
    step();
    reg_ready = 1'b0;
    tl_i.d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rst_mid.no_resp", 32'(tl_o.d_valid), 32'd0);
      check("rst_mid.a_ready", 32'(tl_o.a_ready), 32'd1);
      step();
    end
    tl_i.d_ready = 1'b0;
    run_txn("post_rst", Get, 8'h14, 2'd2, 4'hF, 32'h0, 8'h0D, 0, 32'h0BADF00D, 1'b0,
            1'b1, 1'b0, 8'h14, 4'hF, AccessAckData, 32'h0BADF00D, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
